// File: rtl/knn_pkg.sv
// Shared constants, field offsets and state encoding for the KNN vote stage.
package knn_pkg;

    localparam int KNN_K           = 3;
    localparam int KNN_NUM_CAND    = 12;
    localparam int KNN_DIST_BITS   = 8;
    localparam int KNN_LABEL_BITS  = 4;
    localparam int KNN_NUM_CLASSES = 10;

    localparam int DIST_LSB      = 0;
    localparam int RES_LABEL_LSB = 0;
    localparam int RES_CNT_LSB   = 8;
    localparam int RES_CNT_BITS  = 8;

    localparam logic [KNN_DIST_BITS-1:0]  INIT_DIST = '1;
    localparam logic [KNN_LABEL_BITS-1:0] NO_LABEL  = KNN_LABEL_BITS'(KNN_NUM_CLASSES);

    typedef enum logic [1:0] {
        COLLECT,
        VOTE,
        SEND
    } knn_state_t;

endpackage

// File: rtl/knn_sorted_list.sv
// K-slot list kept in ascending distance order; stable insertion of one candidate per cycle.
module knn_sorted_list
    import knn_pkg::*;
#(
    parameter int                    K          = KNN_K,
    parameter int                    DIST_BITS  = KNN_DIST_BITS,
    parameter int                    LABEL_BITS = KNN_LABEL_BITS,
    parameter logic [DIST_BITS-1:0]  FILL_DIST  = INIT_DIST,
    parameter logic [LABEL_BITS-1:0] FILL_LABEL = NO_LABEL
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    insert,
    input  logic [DIST_BITS-1:0]    in_dist,
    input  logic [LABEL_BITS-1:0]   in_label,
    output logic [K*DIST_BITS-1:0]  dist_flat,
    output logic [K*LABEL_BITS-1:0] label_flat
);

    logic [DIST_BITS-1:0]  dist_q    [K];
    logic [LABEL_BITS-1:0] label_q   [K];
    logic [DIST_BITS-1:0]  dist_nxt  [K];
    logic [LABEL_BITS-1:0] label_nxt [K];
    logic [K-1:0]          beats;

    // beats is monotonic over the sorted list; its first set bit is the insertion slot.
    always_comb begin
        for (int unsigned i = 0; i < K; i++) begin
            beats[i] = dist_q[i] > in_dist;
        end
        dist_nxt[0]  = beats[0] ? in_dist  : dist_q[0];
        label_nxt[0] = beats[0] ? in_label : label_q[0];
        for (int unsigned i = 1; i < K; i++) begin
            dist_nxt[i]  = dist_q[i];
            label_nxt[i] = label_q[i];
            if (beats[i]) begin
                dist_nxt[i]  = beats[i-1] ? dist_q[i-1]  : in_dist;
                label_nxt[i] = beats[i-1] ? label_q[i-1] : in_label;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int unsigned i = 0; i < K; i++) begin
                dist_q[i]  <= FILL_DIST;
                label_q[i] <= FILL_LABEL;
            end
        end else if (insert) begin
            for (int unsigned i = 0; i < K; i++) begin
                dist_q[i]  <= dist_nxt[i];
                label_q[i] <= label_nxt[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < K; i++) begin
            dist_flat[i*DIST_BITS +: DIST_BITS]    = dist_q[i];
            label_flat[i*LABEL_BITS +: LABEL_BITS] = label_q[i];
        end
    end

endmodule

// File: rtl/knn_vote.sv
// Collects NUM_CAND (distance,label) candidates, keeps the K nearest, majority-votes
// over their labels and emits one result word per test digit on an ap_vld/ap_ack stream.
module knn_vote
    import knn_pkg::*;
#(
    parameter int K           = KNN_K,
    parameter int NUM_CAND    = KNN_NUM_CAND,
    parameter int DIST_BITS   = KNN_DIST_BITS,
    parameter int LABEL_BITS  = KNN_LABEL_BITS,
    parameter int NUM_CLASSES = KNN_NUM_CLASSES
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Input_1_V_V,
    input  logic        Input_1_V_V_ap_vld,
    output logic        Input_1_V_V_ap_ack,
    output logic [31:0] Output_1_V_V,
    output logic        Output_1_V_V_ap_vld,
    input  logic        Output_1_V_V_ap_ack
);

    localparam int CNT_W = $clog2(NUM_CAND + 1);
    localparam int VC_W  = $clog2(K + 1);
    localparam int CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int IN_W  = DIST_LSB + DIST_BITS + LABEL_BITS;

    knn_state_t state, state_nxt;

    logic [CNT_W-1:0]        cand_cnt;
    logic [CLS_W-1:0]        cls_idx;
    logic [LABEL_BITS-1:0]   best_label, fin_label;
    logic [VC_W-1:0]         best_cnt, cls_cnt, fin_cnt;
    logic [31:0]             result_word;
    logic                    xfer, last_cand, last_cls, out_done;
    logic [K*DIST_BITS-1:0]  list_dist;
    logic [K*LABEL_BITS-1:0] list_label;
    logic                    unused_bits;

    assign Input_1_V_V_ap_ack  = (state == COLLECT) && !reset;
    assign Output_1_V_V_ap_vld = (state == SEND);
    assign xfer      = Input_1_V_V_ap_vld && Input_1_V_V_ap_ack;
    assign last_cand = (cand_cnt == CNT_W'(NUM_CAND - 1));
    assign last_cls  = (cls_idx == CLS_W'(NUM_CLASSES - 1));
    assign out_done  = (state == SEND) && Output_1_V_V_ap_ack;

    knn_sorted_list #(
        .K          (K),
        .DIST_BITS  (DIST_BITS),
        .LABEL_BITS (LABEL_BITS),
        .FILL_DIST  ('1),
        .FILL_LABEL (LABEL_BITS'(NUM_CLASSES))
    ) u_list (
        .clk        (clk),
        .reset      (reset),
        .clear      (out_done),
        .insert     (xfer),
        .in_dist    (Input_1_V_V[DIST_LSB +: DIST_BITS]),
        .in_label   (Input_1_V_V[DIST_LSB + DIST_BITS +: LABEL_BITS]),
        .dist_flat  (list_dist),
        .label_flat (list_label)
    );

    // Vote ordering only needs labels; distances and the upper input bits are ignored.
    assign unused_bits = ^{list_dist, Input_1_V_V[31:IN_W]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (xfer && last_cand)     state_nxt = VOTE;
            VOTE:    if (last_cls)              state_nxt = SEND;
            SEND:    if (Output_1_V_V_ap_ack)   state_nxt = COLLECT;
            default:                            state_nxt = COLLECT;
        endcase
    end

    // Labels outside 0..NUM_CLASSES-1 never match a scanned class, so they never vote.
    always_comb begin
        cls_cnt = '0;
        for (int unsigned i = 0; i < K; i++) begin
            if (list_label[i*LABEL_BITS +: LABEL_BITS] == LABEL_BITS'(cls_idx)) begin
                cls_cnt = cls_cnt + VC_W'(1);
            end
        end
        fin_label = best_label;
        fin_cnt   = best_cnt;
        if (cls_cnt > best_cnt) begin
            fin_label = LABEL_BITS'(cls_idx);
            fin_cnt   = cls_cnt;
        end
        result_word = '0;
        result_word[RES_LABEL_LSB +: LABEL_BITS]  = fin_label;
        result_word[RES_CNT_LSB +: RES_CNT_BITS]  = RES_CNT_BITS'(fin_cnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_cnt     <= '0;
            cls_idx      <= '0;
            best_label   <= '0;
            best_cnt     <= '0;
            Output_1_V_V <= '0;
        end else begin
            if (xfer) begin
                cand_cnt <= last_cand ? '0 : cand_cnt + CNT_W'(1);
            end
            if (state == VOTE) begin
                if (last_cls) begin
                    cls_idx      <= '0;
                    best_label   <= '0;
                    best_cnt     <= '0;
                    Output_1_V_V <= result_word;
                end else begin
                    cls_idx    <= cls_idx + CLS_W'(1);
                    best_label <= fin_label;
                    best_cnt   <= fin_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// Directed and randomized checks for knn_vote: reset, voting, ties, backpressure, mid-digit reset.
module tb_knn_vote;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_word = '0;
    logic        in_vld = 1'b0;
    logic        in_ack;
    logic [31:0] out_word;
    logic        out_vld;
    logic        out_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    knn_vote #(
        .K           (3),
        .NUM_CAND    (12),
        .DIST_BITS   (8),
        .LABEL_BITS  (4),
        .NUM_CLASSES (10)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .Input_1_V_V         (in_word),
        .Input_1_V_V_ap_vld  (in_vld),
        .Input_1_V_V_ap_ack  (in_ack),
        .Output_1_V_V        (out_word),
        .Output_1_V_V_ap_vld (out_vld),
        .Output_1_V_V_ap_ack (out_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // acc_edge is the number of the posedge on which the candidate transfers.
    task automatic send_cand(input int d, input int l, output bit ok, output int acc_edge);
        int n;
        n = 0;
        @(negedge clk);
        in_word = {20'd0, 4'(l), 8'(d)};
        in_vld  = 1'b1;
        while (!in_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = in_ack;
        acc_edge = cyc + 1;
        @(posedge clk);
        #1 in_vld = 1'b0;
    endtask

    task automatic send_digit(input int ds[12], input int ls[12], input int gap_max,
                              output bit ok, output int first_edge, output int last_edge);
        bit c_ok;
        int e;
        ok = 1'b1;
        first_edge = 0;
        last_edge = 0;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
            send_cand(ds[i], ls[i], c_ok, e);
            if (!c_ok) begin
                ok = 1'b0;
                return;
            end
            if (i == 0) first_edge = e;
            last_edge = e;
        end
    endtask

    task automatic wait_result(output bit ok, output int seen_edge);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_vld && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = out_vld;
        seen_edge = cyc;
    endtask

    task automatic ack_result(output int ack_edge);
        @(negedge clk);
        out_ack = 1'b1;
        ack_edge = cyc + 1;
        @(posedge clk);
        #1 out_ack = 1'b0;
    endtask

    function automatic logic [31:0] model_word(input int ds[12], input int ls[12]);
        int idx[12];
        int cnt[10];
        int j, t, best_l, best_c;
        for (int i = 0; i < 12; i++) idx[i] = i;
        for (int i = 1; i < 12; i++) begin
            j = i;
            while (j > 0 && ds[idx[j-1]] > ds[idx[j]]) begin
                t = idx[j]; idx[j] = idx[j-1]; idx[j-1] = t;
                j--;
            end
        end
        for (int c = 0; c < 10; c++) cnt[c] = 0;
        for (int k = 0; k < 3; k++) begin
            if (ls[idx[k]] < 10) cnt[ls[idx[k]]]++;
        end
        best_l = 0;
        best_c = 0;
        for (int c = 0; c < 10; c++) begin
            if (cnt[c] > best_c) begin
                best_c = cnt[c];
                best_l = c;
            end
        end
        return 32'((best_c << 8) | best_l);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_vld: got %b expected 0", out_vld);
        end
        checks++;
        if (out_word !== 32'h0) begin
            errors++;
            $display("FAIL reset_word: got %h expected 00000000", out_word);
        end
        checks++;
        if (in_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ack: got %b expected 0", in_ack);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ack !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_in_ack: got %b expected 1", in_ack);
        end
    endtask

    task automatic test_majority();
        int ds[12] = '{50, 3, 40, 7, 90, 9, 60, 70, 80, 100, 110, 120};
        int ls[12] = '{1, 7, 1, 2, 1, 7, 1, 1, 1, 1, 1, 1};
        bit ok;
        int fe, le, se, ae;
        send_digit(ds, ls, 0, ok, fe, le);
        @(negedge clk);
        checks++;
        if (in_ack !== 1'b0) begin
            errors++;
            $display("FAIL majority_vote_in_ack: got %b expected 0", in_ack);
        end
        wait_result(ok, se);
        checks++;
        if (!ok || out_word !== 32'h0000_0207) begin
            errors++;
            $display("FAIL majority_word: got %h (vld %b) expected 00000207", out_word, out_vld);
        end
        checks++;
        if (se - le + 1 != 11) begin
            errors++;
            $display("FAIL majority_latency: got %0d expected 11", se - le + 1);
        end
        ack_result(ae);
        @(negedge clk);
        checks++;
        if (out_vld !== 1'b0 || in_ack !== 1'b1) begin
            errors++;
            $display("FAIL majority_after_ack: got vld %b in_ack %b expected vld 0 in_ack 1", out_vld, in_ack);
        end
    endtask

    task automatic test_three_way_tie();
        int ds[12] = '{20, 10, 15, 40, 50, 60, 70, 80, 90, 100, 110, 120};
        int ls[12] = '{9, 4, 1, 5, 5, 5, 5, 5, 5, 5, 5, 5};
        bit ok;
        int fe, le, se, ae;
        send_digit(ds, ls, 1, ok, fe, le);
        wait_result(ok, se);
        checks++;
        if (!ok || out_word !== 32'h0000_0101) begin
            errors++;
            $display("FAIL tie_word: got %h (vld %b) expected 00000101", out_word, out_vld);
        end
        ack_result(ae);
    endtask

    task automatic test_stable_ties();
        int ds[12] = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
        int ls[12] = '{6, 6, 3, 3, 2, 2, 3, 3, 2, 2, 3, 3};
        bit ok;
        int fe, le, se, ae;
        send_digit(ds, ls, 0, ok, fe, le);
        wait_result(ok, se);
        checks++;
        if (!ok || out_word !== 32'h0000_0206) begin
            errors++;
            $display("FAIL stable_word: got %h (vld %b) expected 00000206", out_word, out_vld);
        end
        ack_result(ae);
    endtask

    task automatic test_no_vote();
        int ds[12] = '{1, 2, 3, 40, 50, 60, 70, 80, 90, 100, 110, 120};
        int ls[12] = '{10, 15, 12, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        bit ok;
        int fe, le, se, ae;
        send_digit(ds, ls, 0, ok, fe, le);
        wait_result(ok, se);
        checks++;
        if (!ok || out_word !== 32'h0000_0000) begin
            errors++;
            $display("FAIL no_vote_word: got %h (vld %b) expected 00000000", out_word, out_vld);
        end
        ack_result(ae);
    endtask

    task automatic test_backpressure();
        int ds1[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
        int ls1[12] = '{8, 8, 8, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        int ds2[12] = '{100, 90, 80, 70, 60, 50, 40, 30, 20, 10, 2, 1};
        int ls2[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 3, 3};
        bit ok;
        int fe, le, se, ae;
        int bad;
        send_digit(ds1, ls1, 0, ok, fe, le);
        wait_result(ok, se);
        checks++;
        if (!ok || out_word !== 32'h0000_0308) begin
            errors++;
            $display("FAIL bp_word: got %h (vld %b) expected 00000308", out_word, out_vld);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (out_vld !== 1'b1 || out_word !== 32'h0000_0308 || in_ack !== 1'b0) begin
                errors++;
                bad++;
                if (bad <= 3)
                    $display("FAIL bp_hold cycle %0d: got vld %b word %h in_ack %b expected 1 00000308 0",
                             i, out_vld, out_word, in_ack);
            end
        end
        ack_result(ae);
        send_digit(ds2, ls2, 0, ok, fe, le);
        checks++;
        if (!ok || fe != ae + 1) begin
            errors++;
            $display("FAIL bp_next_accept: got edge %0d expected %0d", fe, ae + 1);
        end
        wait_result(ok, se);
        checks++;
        if (!ok || out_word !== 32'h0000_0203) begin
            errors++;
            $display("FAIL bp_next_word: got %h (vld %b) expected 00000203", out_word, out_vld);
        end
        ack_result(ae);
    endtask

    task automatic test_reset_mid_collect();
        int ds[12] = '{30, 31, 40, 50, 60, 70, 80, 90, 100, 110, 120, 32};
        int ls[12] = '{0, 9, 5, 5, 5, 5, 5, 5, 5, 5, 5, 0};
        bit ok;
        int fe, le, se, ae, e;
        int extra;
        for (int i = 0; i < 5; i++) send_cand(i + 1, 5, ok, e);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_vld !== 1'b0 || in_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got vld %b in_ack %b expected 0 0", out_vld, in_ack);
        end
        reset = 1'b0;
        send_digit(ds, ls, 0, ok, fe, le);
        wait_result(ok, se);
        checks++;
        if (!ok || out_word !== 32'h0000_0200) begin
            errors++;
            $display("FAIL mid_reset_word: got %h (vld %b) expected 00000200", out_word, out_vld);
        end
        checks++;
        if (se - le + 1 != 11) begin
            errors++;
            $display("FAIL mid_reset_latency: got %0d expected 11", se - le + 1);
        end
        ack_result(ae);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_vld === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL mid_reset_extra_result: got %0d valid cycles expected 0", extra);
        end
    endtask

    task automatic test_random();
        int ds[12];
        int ls[12];
        bit ok;
        int fe, le, se, ae;
        logic [31:0] exp_word;
        int shown;
        shown = 0;
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 12; i++) begin
                ds[i] = (n % 2 == 0) ? int'($urandom_range(0, 196)) : int'($urandom_range(0, 12));
                ls[i] = int'($urandom_range(0, 11));
            end
            exp_word = model_word(ds, ls);
            send_digit(ds, ls, 2, ok, fe, le);
            wait_result(ok, se);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (!ok || out_vld !== 1'b1 || out_word !== exp_word) begin
                errors++;
                if (shown < 5)
                    $display("FAIL random digit %0d: got %h (vld %b) expected %h", n, out_word, out_vld, exp_word);
                shown++;
            end
            ack_result(ae);
        end
    endtask

    initial begin
        test_reset();
        test_majority();
        test_three_way_tie();
        test_stable_ties();
        test_no_vote();
        test_backpressure();
        test_reset_mid_collect();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
